ram_stream_reader: RTL and testbench
====================================

Name: ram_stream_reader

Overview:
- Reader counterpart to the single-write-port RAM blocks.
- On a start command, it walks a contiguous address range of an asynchronous-read RAM port. Each word read is emitted on a valid/ready output stream, and the block honours backpressure.
- Sits between any RAM/register-file read port and a streaming consumer such as a DMA, UART TX or checksum unit.

Parameters:
- DWIDTH, 32, data word width (matches the RAM's DWIDTH)
- AWIDTH, 8, RAM address width
- LWIDTH, 9, burst length field width (allows lengths 0..2^AWIDTH)

Ports:
- clk  input  1  single clock; all state changes on posedge
- rst  input  1  reset is asynchronous and active-high
- start  input  1  command strobe; sampled only in IDLE
- base_addr  input  AWIDTH  first address of burst; latched on accepted start
- length  input  LWIDTH  number of words; latched on accepted start
- busy  output  1  high while in RUN or DRAIN
- done  output  1  one-cycle pulse when a burst completes (or a zero-length command is accepted)
- mem_raddr  output  AWIDTH  read address to RAM; registered
- mem_rdata  input  DWIDTH  combinational read data from RAM at mem_raddr
- out_data  output  DWIDTH  stream data; registered
- out_valid  output  1  stream valid
- out_ready  input  1  consumer ready
- out_last  output  1  marks final word of burst; qualified by out_valid

Behaviour:
- Reset (async, any state): state=IDLE, mem_raddr=0, remaining=0, out_data=0, out_valid=0, out_last=0, done=0, busy=0.
- Handshake: a transfer occurs on a posedge with out_valid&&out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_last and out_valid hold stable.
  - out_valid never drops without a transfer, except on reset.
- States: IDLE, RUN, DRAIN. busy = (state != IDLE). done is registered and asserted for exactly one cycle.
- IDLE:
  - start=1 with length!=0: mem_raddr<=base_addr, remaining<=length, go to RUN.
  - start=1 with length==0: stay IDLE; done=1 next cycle; no stream output.
  - start=0: hold.
- RUN:
  - Output register loads when (out_valid==0) or (transfer this cycle).
  - On load: out_data<=mem_rdata, out_valid<=1, out_last<=(remaining==1), mem_raddr<=mem_raddr+1 (mod 2^AWIDTH, wraps 2^AWIDTH-1 -> 0), remaining<=remaining-1.
  - When the load with remaining==1 occurs, go to DRAIN.
- DRAIN:
  - On transfer (out_last is 1): out_valid<=0, out_last<=0, go to IDLE, done<=1.
  - mem_raddr holds its final value (last address + 1, wrapped).
- start is ignored while busy=1: no latching, no effect on the burst.
- Latency and throughput:
  - start accepted at edge k: first word valid after edge k+1.
  - With out_ready held high, one word per cycle; an N-word burst completes with done high in the cycle after edge k+N+1.
  - No bubbles under continuous ready.
- Memory coherence: data is sampled at load time. A RAM write to an address not yet loaded is visible in the stream; a write to an address already loaded is not.
- Width rule: remaining is LWIDTH bits. Lengths > 2^AWIDTH are legal; addresses keep wrapping and are reread.
- Reset mid-burst: all outputs return to reset values immediately (async). No done pulse; a partial stream is abandoned.

Test Plan:
- Basic burst: RAM[i]=0x100+i; base=4, length=3, out_ready=1 -> stream 0x104,0x105,0x106 on consecutive cycles; out_last only on 0x106; done pulses once the cycle after; busy 0 afterwards.
- Backpressure: base=0, length=4, out_ready toggles 1,0,0,1,0,1,1 -> exactly 4 transfers in order 0x100..0x103; data, valid and last stable during stalls; no duplicate or dropped word.
- Wrap-around (AWIDTH=8): base=0xFE, length=4 -> addresses 0xFE,0xFF,0x00,0x01; data RAM[0xFE],RAM[0xFF],RAM[0],RAM[1]; final mem_raddr=0x02.
- Zero length and start-while-busy: length=0 -> done pulse, out_valid never high. Start with base=0x80 pulsed mid-burst -> ignored; original burst unaffected; only one done.
- Reset mid-burst: assert rst between edges after 2 of 5 words -> out_valid, busy, done, mem_raddr go to 0 without waiting for clk. Next start (base=0, length=2) runs normally.
- Back-to-back: start asserted in the same cycle as done -> accepted (state is IDLE); second burst's first word valid two cycles after the last transfer of the first.

Source files
------------

// File: rtl/ram_stream_reader.sv
// Streams a contiguous address range of an async-read RAM port onto a
// valid/ready interface, one word per cycle when the consumer keeps up.
module ram_stream_reader #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8,
    parameter int LWIDTH = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [LWIDTH-1:0] length,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] mem_raddr,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [LWIDTH-1:0] remaining;
    logic              xfer;
    logic              load;
    logic              final_word;

    assign xfer       = out_valid && out_ready;
    // The output register refills whenever it is empty or being emptied.
    assign load       = (state == S_RUN) && (!out_valid || out_ready);
    assign final_word = (remaining == LWIDTH'(1));
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_raddr <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            mem_raddr <= base_addr;
                            remaining <= length;
                            state     <= S_RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (load) begin
                        out_data  <= mem_rdata;
                        out_valid <= 1'b1;
                        out_last  <= final_word;
                        mem_raddr <= mem_raddr + AWIDTH'(1);
                        remaining <= remaining - LWIDTH'(1);
                        if (final_word)
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Only the last word is still held; its transfer ends the burst.
                    if (xfer) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= S_IDLE;
                        done      <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: cycle table for basic, backpressure and
// zero-length bursts, then hand-written wrap, busy-start, reset and back-to-back cases.
module tb_ram_stream_reader;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] length = '0;
    logic          busy, done, out_valid, out_last;
    logic          out_ready = 1'b0;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata, out_data;
    logic [DW-1:0] ram [0:255];

    int n_vec = 0;
    int n_bad = 0;

    assign mem_rdata = ram[mem_raddr];

    always #5 clk = ~clk;

    ram_stream_reader #(.DWIDTH(DW), .AWIDTH(AW), .LWIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    typedef struct packed {
        logic          start;
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        logic          ready;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic          e_last;
        logic          e_done;
        logic          e_busy;
        logic [AW-1:0] e_raddr;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(logic s, logic [AW-1:0] b, logic [LW-1:0] l, logic r,
                                logic v, logic [DW-1:0] d, logic la, logic dn, logic bz,
                                logic [AW-1:0] ra);
        vec_t t;
        t.start = s; t.base = b; t.len = l; t.ready = r;
        t.e_valid = v; t.e_data = d; t.e_last = la; t.e_done = dn; t.e_busy = bz; t.e_raddr = ra;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [AW-1:0] b, input logic [LW-1:0] l);
        start = 1'b1; base_addr = b; length = l;
        step();
        start = 1'b0;
    endtask

    // Runs with ready high until done; checks every transferred word and its last flag.
    // At iteration inj a stray start (base 0x80) is presented to a busy block.
    task automatic collect(input int n, input logic [AW-1:0] b, input int inj);
        int idx = 0;
        int dn = 0;
        logic pv, pl;
        logic [DW-1:0] pd;
        for (int c = 0; c < 64 && dn == 0; c++) begin
            pv = out_valid; pd = out_data; pl = out_last;
            out_ready = 1'b1;
            if (c == inj) begin
                start = 1'b1; base_addr = 8'h80; length = 9'd5;
            end else begin
                start = 1'b0;
            end
            step();
            if (pv) begin
                chk("stream_data", pd, 32'h100 + 32'((int'(b) + idx) % 256));
                chk("stream_last", {31'b0, pl}, {31'b0, idx == n - 1});
                idx++;
            end
            if (done) dn = 1;
        end
        start = 1'b0;
        chk("done_seen", dn, 1);
        chk("word_count", idx, n);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h100 + i;

        // basic burst: base 4, length 3
        tbl[0]  = mk(1, 8'h04, 9'd3, 1, 0, 32'h0,   0, 0, 1, 8'h04);
        tbl[1]  = mk(0, 8'h00, 9'd0, 1, 1, 32'h104, 0, 0, 1, 8'h05);
        tbl[2]  = mk(0, 8'h00, 9'd0, 1, 1, 32'h105, 0, 0, 1, 8'h06);
        tbl[3]  = mk(0, 8'h00, 9'd0, 1, 1, 32'h106, 1, 0, 1, 8'h07);
        tbl[4]  = mk(0, 8'h00, 9'd0, 1, 0, 32'h0,   0, 1, 0, 8'h07);
        tbl[5]  = mk(0, 8'h00, 9'd0, 1, 0, 32'h0,   0, 0, 0, 8'h07);
        // backpressure: base 0, length 4, ready 1,0,0,1,0,1,1 while valid
        tbl[6]  = mk(1, 8'h00, 9'd4, 0, 0, 32'h0,   0, 0, 1, 8'h00);
        tbl[7]  = mk(0, 8'h00, 9'd0, 1, 1, 32'h100, 0, 0, 1, 8'h01);
        tbl[8]  = mk(0, 8'h00, 9'd0, 1, 1, 32'h101, 0, 0, 1, 8'h02);
        tbl[9]  = mk(0, 8'h00, 9'd0, 0, 1, 32'h101, 0, 0, 1, 8'h02);
        tbl[10] = mk(0, 8'h00, 9'd0, 0, 1, 32'h101, 0, 0, 1, 8'h02);
        tbl[11] = mk(0, 8'h00, 9'd0, 1, 1, 32'h102, 0, 0, 1, 8'h03);
        tbl[12] = mk(0, 8'h00, 9'd0, 0, 1, 32'h102, 0, 0, 1, 8'h03);
        tbl[13] = mk(0, 8'h00, 9'd0, 1, 1, 32'h103, 1, 0, 1, 8'h04);
        tbl[14] = mk(0, 8'h00, 9'd0, 1, 0, 32'h0,   0, 1, 0, 8'h04);
        tbl[15] = mk(0, 8'h00, 9'd0, 1, 0, 32'h0,   0, 0, 0, 8'h04);
        // zero length: done pulse only, address untouched
        tbl[16] = mk(1, 8'h55, 9'd0, 1, 0, 32'h0,   0, 1, 0, 8'h04);
        tbl[17] = mk(0, 8'h00, 9'd0, 1, 0, 32'h0,   0, 0, 0, 8'h04);

        // reset state
        #12;
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_busy",  {31'b0, busy}, 0);
        chk("rst_done",  {31'b0, done}, 0);
        chk("rst_raddr", {24'b0, mem_raddr}, 0);
        chk("rst_data",  out_data, 0);
        @(negedge clk) rst = 1'b0;
        step();

        for (int i = 0; i < 18; i++) begin
            start = tbl[i].start; base_addr = tbl[i].base;
            length = tbl[i].len;  out_ready = tbl[i].ready;
            step();
            chk($sformatf("tbl%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].e_valid});
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_data", i), out_data, tbl[i].e_data);
                chk($sformatf("tbl%0d_last", i), {31'b0, out_last}, {31'b0, tbl[i].e_last});
            end
            chk($sformatf("tbl%0d_done", i),  {31'b0, done}, {31'b0, tbl[i].e_done});
            chk($sformatf("tbl%0d_busy", i),  {31'b0, busy}, {31'b0, tbl[i].e_busy});
            chk($sformatf("tbl%0d_raddr", i), {24'b0, mem_raddr}, {24'b0, tbl[i].e_raddr});
        end
        start = 1'b0;

        // wrap-around
        go(8'hFE, 9'd4);
        collect(4, 8'hFE, -1);
        chk("wrap_raddr", {24'b0, mem_raddr}, 32'h02);
        step();

        // start while busy is ignored; exactly one done
        go(8'h10, 9'd3);
        collect(3, 8'h10, 1);
        chk("busy_start_raddr", {24'b0, mem_raddr}, 32'h13);
        step();
        chk("busy_start_done_once", {31'b0, done}, 0);
        chk("busy_start_idle", {31'b0, busy}, 0);
        chk("busy_start_novalid", {31'b0, out_valid}, 0);

        // reset mid-burst after two transfers
        go(8'h20, 9'd5);
        out_ready = 1'b1;
        step(); step(); step();
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", {31'b0, out_valid}, 0);
        chk("midrst_busy",  {31'b0, busy}, 0);
        chk("midrst_done",  {31'b0, done}, 0);
        chk("midrst_raddr", {24'b0, mem_raddr}, 0);
        @(negedge clk) rst = 1'b0;
        step();
        chk("postrst_done", {31'b0, done}, 0);
        go(8'h00, 9'd2);
        collect(2, 8'h00, -1);
        step();

        // back-to-back: new start in the done cycle
        go(8'h30, 9'd2);
        collect(2, 8'h30, -1);
        start = 1'b1; base_addr = 8'h40; length = 9'd2;
        step();
        start = 1'b0;
        chk("b2b_accept_busy", {31'b0, busy}, 1);
        chk("b2b_accept_novalid", {31'b0, out_valid}, 0);
        step();
        chk("b2b_first_valid", {31'b0, out_valid}, 1);
        chk("b2b_first_data", out_data, 32'h140);
        collect(2, 8'h40, -1);
        chk("b2b_raddr", {24'b0, mem_raddr}, 32'h42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
